// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data-memory controller (optional busy timeout: DMEM_TIMEOUT_EN)
module dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] addr_aligned,
  input  logic [1:0]  bit_shift,
  input  logic [3:0]  mem_byte_enable,
  input  logic [3:0]  rmask,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  input  logic        advance,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        dmem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_q, shifted, extended;
  logic [3:0]  wmask_q;
  logic [1:0]  shift_q;
  logic [2:0]  funct3_q;
  logic        is_write_q;
  logic        pending, busy, timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  assign pending = req_valid && (mem_byte_enable != 4'b0 || rmask != 4'b0);
  assign busy    = (state_q == BUSY);

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;

  // Resp in the same cycle as the limit completes normally.
  assign timeout = busy && !dmem_resp && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= busy ? cnt_q + 16'd1 : '0;
      if (timeout)
        err_q <= 1'b1;
      else if (state_q == DONE && advance)
        err_q <= 1'b0;
    end
  end

  assign dmem_err = err_q;
`else
  assign timeout  = 1'b0;
  assign dmem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_resp || timeout)
          state_d = DONE;
      end
      DONE: begin
        if (advance)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted  = dmem_rdata >> {shift_q, 3'b000};
    extended = '0;
    case (funct3_q)
      3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  extended = shifted;
      3'b100:  extended = {24'b0, shifted[7:0]};
      3'b101:  extended = {16'b0, shifted[15:0]};
      default: extended = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      shift_q    <= '0;
      funct3_q   <= '0;
      is_write_q <= 1'b0;
      load_q     <= '0;
    end else begin
      if (state_q == IDLE && pending) begin
        addr_q     <= addr_aligned;
        wdata_q    <= write_data << {bit_shift, 3'b000};
        wmask_q    <= mem_byte_enable;
        shift_q    <= bit_shift;
        funct3_q   <= funct3;
        is_write_q <= (mem_byte_enable != 4'b0);
      end
      if (busy && dmem_resp && !is_write_q)
        load_q <= extended;
      else if (timeout)
        load_q <= '0;
    end
  end

  // Request fields are only driven while a transaction is outstanding.
  assign dmem_read    = busy && !is_write_q;
  assign dmem_write   = busy && is_write_q;
  assign dmem_address = busy ? addr_q  : '0;
  assign dmem_wmask   = busy ? wmask_q : '0;
  assign dmem_wdata   = busy ? wdata_q : '0;
  assign load_data    = load_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector bench for dmem_ctrl
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] addr_aligned;
  logic [1:0]  bit_shift;
  logic [3:0]  mem_byte_enable;
  logic [3:0]  rmask;
  logic [2:0]  funct3;
  logic [31:0] write_data;
  logic        advance;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall;
  logic [31:0] load_data;
  logic        dmem_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .addr_aligned(addr_aligned),
    .bit_shift(bit_shift), .mem_byte_enable(mem_byte_enable), .rmask(rmask),
    .funct3(funct3), .write_data(write_data), .advance(advance),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .load_data(load_data), .dmem_err(dmem_err)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  sh;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          k;
    logic [31:0] exp_ld;
    logic [31:0] exp_wd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    req_valid       = 1'b1;
    addr_aligned    = v.addr;
    bit_shift       = v.sh;
    mem_byte_enable = v.wm;
    rmask           = v.rm;
    funct3          = v.f3;
    write_data      = v.wd;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    drive_req(v);
    #1;
    chk({tag, " c0 stall"}, 32'(stall), 32'd1);
    chk({tag, " c0 req"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    for (int c = 1; c <= v.k; c++) begin
      tick();
      if (c == 1) begin
        addr_aligned = 32'hFFFF_FFF0;
        write_data   = 32'h5A5A_5A5A;
        bit_shift    = ~v.sh;
      end
      chk({tag, " busy stall"}, 32'(stall), 32'd1);
      chk({tag, " busy read"}, 32'(dmem_read), 32'(!v.exp_wr));
      chk({tag, " busy write"}, 32'(dmem_write), 32'(v.exp_wr));
      chk({tag, " busy addr"}, dmem_address, v.addr);
      chk({tag, " busy wmask"}, 32'(dmem_wmask), 32'(v.wm));
      chk({tag, " busy wdata"}, dmem_wdata, v.exp_wd);
      chk({tag, " busy err"}, 32'(dmem_err), 32'd0);
      if (c == v.k) begin
        dmem_resp  = 1'b1;
        dmem_rdata = v.rd;
      end
    end
    tick();
    dmem_resp = 1'b0;
    req_valid = 1'b0;
    chk({tag, " done stall"}, 32'(stall), 32'd0);
    chk({tag, " done req"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    chk({tag, " load_data"}, load_data, v.exp_ld);
    chk({tag, " done err"}, 32'(dmem_err), 32'd0);
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  initial begin
    //          f3      sh     rm       wm       addr           wd             rd             k  exp_ld         exp_wd         wr
    vecs[0]  = '{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{3'b000, 2'd3, 4'b1000, 4'b0000, 32'h0000_0200, 32'h0,         32'h8012_3456, 1, 32'hFFFF_FF80, 32'h0,         1'b0};
    vecs[2]  = '{3'b100, 2'd3, 4'b1000, 4'b0000, 32'h0000_0200, 32'h0,         32'h8012_3456, 2, 32'h0000_0080, 32'h0,         1'b0};
    vecs[3]  = '{3'b001, 2'd2, 4'b1100, 4'b0000, 32'h0000_0204, 32'h0,         32'h7FFF_0000, 1, 32'h0000_7FFF, 32'h0,         1'b0};
    vecs[4]  = '{3'b000, 2'd1, 4'b0000, 4'b0010, 32'h0000_0208, 32'h0000_00AB, 32'h1234_5678, 2, 32'h0000_7FFF, 32'h0000_AB00, 1'b1};
    vecs[5]  = '{3'b101, 2'd2, 4'b1100, 4'b0000, 32'h0000_020C, 32'h0,         32'h8001_0000, 1, 32'h0000_8001, 32'h0,         1'b0};
    vecs[6]  = '{3'b001, 2'd0, 4'b0011, 4'b0000, 32'h0000_0210, 32'h0,         32'h0000_8001, 2, 32'hFFFF_8001, 32'h0,         1'b0};
    vecs[7]  = '{3'b010, 2'd0, 4'b1111, 4'b1111, 32'h0000_0214, 32'h1122_3344, 32'hFFFF_FFFF, 1, 32'hFFFF_8001, 32'h1122_3344, 1'b1};
    vecs[8]  = '{3'b011, 2'd0, 4'b1111, 4'b0000, 32'h0000_0218, 32'h0,         32'h1234_5678, 1, 32'h0000_0000, 32'h0,         1'b0};
    vecs[9]  = '{3'b000, 2'd0, 4'b0001, 4'b0000, 32'h0000_021C, 32'h0,         32'h0000_007F, 1, 32'h0000_007F, 32'h0,         1'b0};
    vecs[10] = '{3'b010, 2'd0, 4'b0000, 4'b1111, 32'h0000_0220, 32'hCAFE_F00D, 32'h0,         3, 32'h0000_007F, 32'hCAFE_F00D, 1'b1};

    rst = 1'b0;
    req_valid = 1'b0; addr_aligned = '0; bit_shift = '0; mem_byte_enable = '0;
    rmask = '0; funct3 = '0; write_data = '0; advance = 1'b0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    tick();
    tick();
    chk("reset outputs", {dmem_address | dmem_wdata | load_data}, 32'd0);
    chk("reset flags", {26'd0, dmem_read, dmem_write, dmem_wmask[1:0] | dmem_wmask[3:2], stall, dmem_err}, 32'd0);
    rst = 1'b1;
    tick();

    // No request: valid without masks, or masks without valid.
    req_valid = 1'b1; rmask = 4'b0000; mem_byte_enable = 4'b0000;
    #1;
    chk("no-mask stall", 32'(stall), 32'd0);
    req_valid = 1'b0; rmask = 4'b1111;
    tick();
    chk("no-valid stall", 32'(stall), 32'd0);
    chk("no-valid read", 32'(dmem_read), 32'd0);
    rmask = 4'b0000;

    for (int i = 0; i < 11; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // DONE hold with the request still live.
    drive_req('{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0400, 32'h0, 32'h0, 1, 32'h0, 32'h0, 1'b0});
    tick();
    chk("hold busy read", 32'(dmem_read), 32'd1);
    dmem_resp = 1'b1; dmem_rdata = 32'h55AA_55AA;
    tick();
    dmem_resp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("hold done req", {30'd0, dmem_read, dmem_write}, 32'd0);
      chk("hold done stall", 32'(stall), 32'd0);
      tick();
    end
    advance = 1'b1;
    #1;
    chk("hold adv stall", 32'(stall), 32'd0);
    tick();
    advance = 1'b0;
    chk("reissue idle stall", 32'(stall), 32'd1);
    chk("reissue idle read", 32'(dmem_read), 32'd0);
    chk("hold load", load_data, 32'h55AA_55AA);
    tick();
    chk("reissue busy read", 32'(dmem_read), 32'd1);
    chk("reissue busy addr", dmem_address, 32'h0000_0400);
    dmem_resp = 1'b1; dmem_rdata = 32'h0102_0304;
    tick();
    dmem_resp = 1'b0; req_valid = 1'b0;
    chk("reissue load", load_data, 32'h0102_0304);
    advance = 1'b1;
    tick();
    advance = 1'b0;

    // Asynchronous reset while BUSY, then a stray response.
    drive_req('{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0300, 32'h0, 32'h0, 1, 32'h0, 32'h0, 1'b0});
    tick();
    chk("mid-busy read", 32'(dmem_read), 32'd1);
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async rst read", 32'(dmem_read), 32'd0);
    chk("async rst stall", 32'(stall), 32'd0);
    chk("async rst addr", dmem_address, 32'd0);
    chk("async rst load", load_data, 32'd0);
    tick();
    rst = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_resp = 1'b0;
    chk("stray resp stall", 32'(stall), 32'd0);
    chk("stray resp read", 32'(dmem_read), 32'd0);
    chk("stray resp load", load_data, 32'd0);
    tick();
    run_txn('{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0304, 32'h0, 32'h600D_F00D, 2, 32'h600D_F00D, 32'h0, 1'b0}, "post-rst");

`ifdef DMEM_TIMEOUT_EN
    drive_req('{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0500, 32'h0, 32'h0, 1, 32'h0, 32'h0, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to busy read", 32'(dmem_read), 32'd1);
      chk("to busy err", 32'(dmem_err), 32'd0);
    end
    tick();
    req_valid = 1'b0;
    chk("to err", 32'(dmem_err), 32'd1);
    chk("to load", load_data, 32'd0);
    chk("to stall", 32'(stall), 32'd0);
    chk("to read", 32'(dmem_read), 32'd0);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    chk("to err clear", 32'(dmem_err), 32'd0);
    run_txn('{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0504, 32'h0, 32'hA5A5_0001, 4, 32'hA5A5_0001, 32'h0, 1'b0}, "resp-at-limit");
`else
    run_txn('{3'b010, 2'd0, 4'b1111, 4'b0000, 32'h0000_0508, 32'h0, 32'hA5A5_0002, 300, 32'hA5A5_0002, 32'h0, 1'b0}, "long-wait");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

MEM-stage data-memory controller: the responder side of the memory request produced by the EX/MEM pipeline register (aligned address, byte shift, write/read masks, store data). Turns each valid load/store into a single held-request transaction on the data-memory port, stalls the pipeline until the response arrives, and returns the shifted and sign/zero-extended load result to MEM/WB. Holds the result, without reissuing, until the pipeline advances.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY-cycle limit before an error abort. Used only with `DMEM_TIMEOUT_EN`.
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `req_valid`  in  1  EX/MEM slot holds a live instruction
- `addr_aligned`  in  32  word address, bits [1:0] = 00
- `bit_shift`  in  2  original addr[1:0]
- `mem_byte_enable`  in  4  store write mask, already shifted
- `rmask`  in  4  load read mask, already shifted
- `funct3`  in  3  load width/sign: lb=000 lh=001 lw=010 lbu=100 lhu=101
- `write_data`  in  32  unshifted store data (rs2)
- `advance`  in  1  MEM/WB accepts this slot this cycle
- `dmem_address`  out  32  held request address
- `dmem_read`  out  1  read request, level-held until response
- `dmem_write`  out  1  write request, level-held until response
- `dmem_wmask`  out  4  held write mask
- `dmem_wdata`  out  32  `write_data << (8*bit_shift)`, held
- `dmem_rdata`  in  32  read data, valid with `dmem_resp`
- `dmem_resp`  in  1  one-cycle completion pulse
- `stall`  out  1  freeze upstream pipeline registers
- `load_data`  out  32  extended load result, registered
- `dmem_err`  out  1  timeout abort flag, sticky until `advance`

## Operation
- States: IDLE, BUSY, DONE.
- A request is pending when `req_valid` and (`mem_byte_enable` != 0 or `rmask` != 0).
- IDLE, request pending:
  - Capture address, masks, shifted wdata, `bit_shift` and `funct3`.
  - Set `dmem_write` if `mem_byte_enable` != 0; otherwise set `dmem_read`. Write wins if both masks are nonzero; the read is suppressed.
  - Go to BUSY.
- IDLE, no request: remain in IDLE. All `dmem_*` outputs stay low/zero. No stall.
- BUSY:
  - Outputs hold the captured values; inputs are ignored.
  - On `dmem_resp`: drop `dmem_read`/`dmem_write` and go to DONE.
  - If the access was a read, also register `load_data`:
    - `r = dmem_rdata >> (8*bit_shift)`
    - lb: sign-extend r[7:0]
    - lbu: zero-extend r[7:0]
    - lh: sign-extend r[15:0]
    - lhu: zero-extend r[15:0]
    - lw: r
    - Any other funct3: 0.
  - Stores leave `load_data` unchanged.
- DONE:
  - No memory request is issued.
  - If `advance`, go to IDLE; otherwise hold DONE indefinitely. An external stall never causes a duplicate access.
- `stall` = (IDLE and request pending) or BUSY. It is combinational, so `stall` is 0 in DONE.
- `dmem_resp` outside BUSY is ignored.
- Reset, async at any time including mid-BUSY:
  - State goes to IDLE.
  - All outputs and held registers go to 0.
  - The in-flight memory transaction is abandoned. The memory side must tolerate this.

## Timing
- Request seen in cycle 0 (IDLE). `dmem_read`/`dmem_write` are high from cycle 1.
- `dmem_resp` in cycle k ≥ 1 → DONE and `load_data` valid in cycle k+1. `stall` is high in cycles 0..k.
- Minimum occupancy: 2 stall cycles plus 1 DONE cycle.
- DONE with `advance` in cycle j → IDLE in j+1. A new request may be captured in j+1.
- `load_data` holds from DONE entry until the next read response or reset.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider BUSY cycle counter clears on entering BUSY.
  - When it reaches `TIMEOUT_CYCLES` without `dmem_resp`: drop requests, set `dmem_err`, force `load_data` to 0, go to DONE.
  - `dmem_err` clears on `advance` in DONE or on reset.
  - A `dmem_resp` in the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; `dmem_err` tied 0.

## Test plan
- lw, addr 0x100, rmask 1111, resp in cycle 3 with rdata 0xDEADBEEF → `dmem_read` high cycles 1–3, `stall` high 0–3, `load_data` 0xDEADBEEF in cycle 4.
- lb, bit_shift 3, rmask 1000, rdata 0x80123456 → `load_data` 0xFFFFFF80. Same access as lbu → 0x00000080. lh, bit_shift 2, rdata 0x7FFF0000 → 0x00007FFF.
- sb, bit_shift 1, write_data 0x000000AB, wmask 0010 → `dmem_write` 1, `dmem_wdata` 0x0000AB00, `dmem_wmask` 0010, `dmem_read` 0, `load_data` unchanged.
- Hold `advance` low 5 cycles in DONE with `req_valid` still high → no second `dmem_read`/`dmem_write`, `stall` 0; `advance` 1 → IDLE next cycle, then a new request is captured.
- Drive `rst` low mid-BUSY → all outputs 0 immediately (asynchronous), state IDLE. After release, a stray `dmem_resp` causes no transition.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no response → `dmem_err` 1 and `load_data` 0 at DONE, `stall` drops. Repeat with resp on the 4th BUSY cycle → `dmem_err` 0.
